netwalk_match_encoder: RTL and testbench

- Parametrised, handshaked successor to the one-hot NetWalk encoder.
- Accepts a match vector from the flow-table CAM with any number of bits set, not just one-hot.
- Serially emits the index of every set bit, lowest index first, one index per output handshake, and flags the last one.
- Sits between the CAM match lines and the action/rule-fetch stage of the data plane.

---
 rtl/netwalk_pkg.sv | 21 ++
 rtl/netwalk_prio_scan.sv | 39 +++
 rtl/netwalk_match_encoder.sv | 101 ++++++++++
 tb/tb_netwalk_match_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/netwalk_pkg.sv
// Shared types and helpers for the NetWalk match encoder.
// Build option: NETWALK_MATCH_MSB_FIRST_EN selects highest-index-first emission.
package netwalk_pkg;

    localparam int ENCODER_OUT_WIDTH_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        NOMATCH = 2'd2
    } state_t;

    function automatic bit scan_msb_first();
`ifdef NETWALK_MATCH_MSB_FIRST_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

endpackage

// File: rtl/netwalk_prio_scan.sv
// Combinational priority scan: picks the first set bit of a vector in the
// configured direction and reports whether it is the only one left.
module netwalk_prio_scan #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 6,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [IN_WIDTH-1:0]  vec,
    output logic                 found,
    output logic [OUT_WIDTH-1:0] index,
    output logic                 single_remaining
);

    localparam logic [IN_WIDTH-1:0] ONE = IN_WIDTH'(1);

    always_comb begin
        found = 1'b0;
        index = '0;
        // The last assignment in loop order wins, so iterate away from the preferred end.
        if (MSB_FIRST) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (vec[i]) begin
                    found = 1'b1;
                    index = OUT_WIDTH'(i);
                end
            end
        end else begin
            for (int i = IN_WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    found = 1'b1;
                    index = OUT_WIDTH'(i);
                end
            end
        end
    end

    assign single_remaining = found && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/netwalk_match_encoder.sv
// Serialises a multi-hot CAM match vector into one index per output beat.
// Build option: NETWALK_MATCH_MSB_FIRST_EN emits highest index first.
module netwalk_match_encoder
    import netwalk_pkg::*;
#(
    parameter int ENCODER_OUT_WIDTH = ENCODER_OUT_WIDTH_DEFAULT,
    parameter int ENCODER_IN_WIDTH  = 1 << ENCODER_OUT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ENCODER_IN_WIDTH-1:0]  encoder_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [ENCODER_OUT_WIDTH-1:0] encoder_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         out_nomatch,
    output logic [1:0]                   dbg_state
);

    // valid/ready: a beat transfers on a rising clk when both are high; the
    // producer holds its payload stable while valid is high and ready is low.

    localparam logic [ENCODER_IN_WIDTH-1:0] BIT0 = ENCODER_IN_WIDTH'(1);

    state_t                        state;
    logic [ENCODER_IN_WIDTH-1:0]   pending;
    logic [ENCODER_IN_WIDTH-1:0]   next_vec;
    logic                          in_fire;
    logic                          out_fire;
    logic                          scan_found;
    logic [ENCODER_OUT_WIDTH-1:0]  scan_index;
    logic                          scan_single;

    assign out_fire  = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (out_fire && out_last);
    assign in_fire   = in_valid && in_ready;
    assign dbg_state = state;

    // The scan looks at what the pending vector will be after this edge, so the
    // next index is already registered when the beat is presented.
    always_comb begin
        next_vec = pending;
        if (in_fire) begin
            next_vec = encoder_in;
        end else if (out_fire) begin
            next_vec = pending & ~(BIT0 << encoder_out);
        end
    end

    netwalk_prio_scan #(
        .IN_WIDTH  (ENCODER_IN_WIDTH),
        .OUT_WIDTH (ENCODER_OUT_WIDTH),
        .MSB_FIRST (scan_msb_first())
    ) u_scan (
        .vec              (next_vec),
        .found            (scan_found),
        .index            (scan_index),
        .single_remaining (scan_single)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pending     <= '0;
            out_valid   <= 1'b0;
            encoder_out <= '0;
            out_last    <= 1'b0;
            out_nomatch <= 1'b0;
        end else if (in_fire) begin
            pending   <= next_vec;
            out_valid <= 1'b1;
            if (scan_found) begin
                state       <= EMIT;
                encoder_out <= scan_index;
                out_last    <= scan_single;
                out_nomatch <= 1'b0;
            end else begin
                state       <= NOMATCH;
                encoder_out <= '0;
                out_last    <= 1'b1;
                out_nomatch <= 1'b1;
            end
        end else if (out_fire) begin
            if (out_last) begin
                state       <= IDLE;
                pending     <= '0;
                out_valid   <= 1'b0;
                encoder_out <= '0;
                out_last    <= 1'b0;
                out_nomatch <= 1'b0;
            end else begin
                pending     <= next_vec;
                encoder_out <= scan_index;
                out_last    <= scan_single;
            end
        end
    end

endmodule

// File: tb/tb_netwalk_match_encoder.sv
// Self-checking bench for netwalk_match_encoder (default 64-bit vector, 6-bit index).
// Follows NETWALK_MATCH_MSB_FIRST_EN for the expected emission order.
module tb_netwalk_match_encoder;

  logic        clk;
  logic        reset;
  logic [63:0] encoder_in;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  encoder_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_nomatch;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // {nomatch, last, index}
  logic [7:0] exp_q[$];

  int cur_cnt    = 0;
  int cur_first  = 0;
  int last_first = -1;
  int last_count = -1;

  typedef struct {
    logic [63:0] vec;
    int          first_lsb;
    int          first_msb;
    int          beats;
  } vec_t;

  vec_t tbl[8];

  netwalk_match_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .encoder_in  (encoder_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .encoder_out (encoder_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_nomatch (out_nomatch),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expected(input logic [63:0] v);
    int total;
    int seen;
    total = $countones(v);
    seen  = 0;
    if (v == 64'h0) begin
      exp_q.push_back({1'b1, 1'b1, 6'd0});
    end else begin
`ifdef NETWALK_MATCH_MSB_FIRST_EN
      for (int i = 63; i >= 0; i--) begin
`else
      for (int i = 0; i < 64; i++) begin
`endif
        if (v[i]) begin
          seen++;
          exp_q.push_back({1'b0, (seen == total), 6'(i)});
        end
      end
    end
  endtask

  // driver tasks
  task automatic send(input logic [63:0] v);
    int k;
    @(negedge clk);
    encoder_in = v;
    in_valid   = 1'b1;
    k = 0;
    #1;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      push_expected(v);
      @(posedge clk);
    end
  endtask

  task automatic drain(input bit rnd);
    int k;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 400) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      k++;
    end
    out_ready = 1'b1;
    if (k >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
  endtask

  // scoreboard / monitor: samples 1 time unit before each rising edge
  logic       have_stall = 1'b0;
  logic [7:0] stall_snap;

  always @(negedge clk) begin
    logic [7:0] got;
    logic [7:0] exp;
    #4;
    if (reset) begin
      got = {out_nomatch, out_last, encoder_out};
      if (have_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_hold", got, stall_snap);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          chk("beat", got, exp);
        end
        if (cur_cnt == 0) cur_first = int'(encoder_out);
        cur_cnt++;
        if (out_last) begin
          last_first = cur_first;
          last_count = cur_cnt;
          cur_cnt    = 0;
        end
      end
      have_stall = out_valid && !out_ready;
      stall_snap = got;
    end else begin
      have_stall = 1'b0;
      cur_cnt    = 0;
    end
  end

  initial begin
    logic [63:0] rv;
    int exp_first;

    tbl[0] = '{64'h0000_0000_0000_0001,  0,  0,  1};
    tbl[1] = '{64'h8000_0000_0000_0000, 63, 63,  1};
    tbl[2] = '{64'h0000_0800_0000_0048,  3, 43,  3};
    tbl[3] = '{64'h0000_0000_0000_0000,  0,  0,  1};
    tbl[4] = '{64'hF000_0000_0000_000F,  0, 63,  8};
    tbl[5] = '{64'h0000_0001_0000_0000, 32, 32,  1};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF,  0, 63, 64};
    tbl[7] = '{64'h0010_0200_0400_8000, 15, 52,  4};

    reset      = 1'b0;
    encoder_in = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_encoder_out", encoder_out, 6'd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_nomatch", out_nomatch, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_state", dbg_state, 2'd0);
    @(negedge clk);
    reset = 1'b1;

    // table-driven vectors, full throughput
    for (int t = 0; t < 8; t++) begin
`ifdef NETWALK_MATCH_MSB_FIRST_EN
      exp_first = tbl[t].first_msb;
`else
      exp_first = tbl[t].first_lsb;
`endif
      send(tbl[t].vec);
      drain(1'b0);
      chk("tbl_first", 64'(last_first), 64'(exp_first));
      chk("tbl_beats", 64'(last_count), 64'(tbl[t].beats));
    end

    // first beat one cycle after accept
    send(64'h1);
    #1;
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_index", encoder_out, 6'd0);
    chk("lat_last", out_last, 1'b1);
    drain(1'b0);

    // multi-match beats on consecutive cycles
    send(64'h0000_0800_0000_0048);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("consec_valid", out_valid, 1'b1);
      @(negedge clk);
    end
    drain(1'b0);

    // backpressure on the second beat (index 6 in either order)
    send(64'h0000_0800_0000_0048);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_index", encoder_out, 6'd6);
      chk("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain(1'b0);

    // back-to-back: second vector taken on the last-beat handshake
    send(64'h1);
    send(64'h4000_0000_0000_0000);
    #1;
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_index", encoder_out, 6'd62);
    chk("b2b_last", out_last, 1'b1);
    drain(1'b0);

    // asynchronous reset in the middle of an emission
    out_ready = 1'b0;
    send(64'h0000_0800_0000_0048);
    @(negedge clk);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_index", encoder_out, 6'd0);
    chk("arst_last", out_last, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("arst_quiet", out_valid, 1'b0);
    end
    send(64'h4);
    #1;
    chk("arst_new_index", encoder_out, 6'd2);
    chk("arst_new_valid", out_valid, 1'b1);
    drain(1'b0);

    // random sparse vectors with random downstream stalls
    for (int r = 0; r < 15; r++) begin
      rv = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if (r == 7) rv = 64'h0;
      send(rv);
      drain(1'b1);
      chk("rnd_beats", 64'(last_count), (rv == 64'h0) ? 64'd1 : 64'($countones(rv)));
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
